mem_arbiter: RTL and testbench

- Shares the single unified memory port of the RV CPU top between the instruction-fetch requester and the load/store requester.
- Data accesses have priority by default. A starvation counter forces a fetch grant after a bounded run of data grants.
- A watchdog ends any memory transaction that never acknowledges, so the core always reaches halted and the bench can still check x10.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for the unified memory port: load/store has priority over fetch, with
// starvation relief for fetch and a watchdog that aborts unacknowledged accesses.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [CW-1:0]  starve_cnt;
  logic [CW-1:0]  starve_nxt;
  logic [WW-1:0]  wdog;
  logic [WW-1:0]  wdog_nxt;
  logic           gnt_d;
  logic           gnt_d_nxt;

  logic           i_ready_nxt;
  logic [DW-1:0]  i_rdata_nxt;
  logic           d_ready_nxt;
  logic [DW-1:0]  d_rdata_nxt;
  logic           m_req_nxt;
  logic           m_we_nxt;
  logic [SW-1:0]  m_wstrb_nxt;
  logic [AW-1:0]  m_addr_nxt;
  logic [DW-1:0]  m_wdata_nxt;
  logic           bus_err_nxt;

  logic           any_req;
  logic           pick_i;
  logic           starved;
  logic           wdog_hit;

  assign any_req  = i_req | d_req;
  assign starved  = (starve_cnt == CW'(STARVE_MAX));
  assign pick_i   = i_req & (~d_req | starved);
  assign wdog_hit = (wdog == WW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (m_ack || wdog_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and grant owner
  always_comb begin
    i_ready_nxt = 1'b0;
    d_ready_nxt = 1'b0;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    m_req_nxt   = m_req;
    m_we_nxt    = m_we;
    m_wstrb_nxt = m_wstrb;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    bus_err_nxt = bus_err;
    starve_nxt  = starve_cnt;
    wdog_nxt    = wdog;
    gnt_d_nxt   = gnt_d;

    case (state)
      IDLE: begin
        wdog_nxt = '0;
        if (!i_req) starve_nxt = '0;
        if (any_req) begin
          m_req_nxt = 1'b1;
          if (pick_i) begin
            gnt_d_nxt   = 1'b0;
            m_we_nxt    = 1'b0;
            m_wstrb_nxt = '0;
            m_addr_nxt  = i_addr;
            m_wdata_nxt = '0;
            starve_nxt  = '0;
          end else begin
            gnt_d_nxt   = 1'b1;
            m_we_nxt    = d_we;
            m_wstrb_nxt = d_we ? d_wstrb : SW'(0);
            m_addr_nxt  = d_addr;
            m_wdata_nxt = d_wdata;
            // Only data wins that hold off a waiting fetch count toward starvation
            if (i_req && !starved) starve_nxt = starve_cnt + CW'(1);
          end
        end
      end

      BUSY: begin
        if (m_ack) begin
          m_req_nxt = 1'b0;
          wdog_nxt  = '0;
          if (gnt_d) begin
            d_ready_nxt = 1'b1;
            d_rdata_nxt = m_rdata;
          end else begin
            i_ready_nxt = 1'b1;
            i_rdata_nxt = m_rdata;
          end
        end else if (wdog_hit) begin
          m_req_nxt   = 1'b0;
          wdog_nxt    = '0;
          bus_err_nxt = 1'b1;
          if (gnt_d) begin
            d_ready_nxt = 1'b1;
            d_rdata_nxt = '0;
          end else begin
            i_ready_nxt = 1'b1;
            i_rdata_nxt = '0;
          end
        end else begin
          wdog_nxt = wdog + WW'(1);
        end
      end

      default: ;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ready    <= 1'b0;
      i_rdata    <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_wstrb    <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      wdog       <= '0;
      gnt_d      <= 1'b0;
    end else begin
      i_ready    <= i_ready_nxt;
      i_rdata    <= i_rdata_nxt;
      d_ready    <= d_ready_nxt;
      d_rdata    <= d_rdata_nxt;
      m_req      <= m_req_nxt;
      m_we       <= m_we_nxt;
      m_wstrb    <= m_wstrb_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      bus_err    <= bus_err_nxt;
      starve_cnt <= starve_nxt;
      wdog       <= wdog_nxt;
      gnt_d      <= gnt_d_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        bus_err;

  mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: owner 0=none 1=fetch 2=data
  int          owner = 0;
  bit          resp_due = 1'b0;
  int          age = 0;
  int          run = 0;
  logic        e_i_ready = 1'b0, e_d_ready = 1'b0, e_m_req = 1'b0, e_m_we = 1'b0, e_bus_err = 1'b0;
  logic [31:0] e_i_rdata = '0, e_d_rdata = '0, e_m_addr = '0, e_m_wdata = '0;
  logic [3:0]  e_m_wstrb = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 0; resp_due <= 1'b0; age <= 0; run <= 0;
      e_i_ready <= 1'b0; e_d_ready <= 1'b0; e_m_req <= 1'b0; e_m_we <= 1'b0;
      e_bus_err <= 1'b0; e_i_rdata <= '0; e_d_rdata <= '0; e_m_addr <= '0;
      e_m_wdata <= '0; e_m_wstrb <= '0;
    end else begin
      e_i_ready <= 1'b0;
      e_d_ready <= 1'b0;
      if (resp_due) begin
        resp_due <= 1'b0;
      end else if (owner == 0) begin
        if (i_req && (!d_req || run == SMAX)) begin
          owner <= 1; run <= 0; e_m_req <= 1'b1; age <= 0;
          e_m_we <= 1'b0; e_m_wstrb <= 4'b0000; e_m_addr <= i_addr;
        end else if (d_req) begin
          owner <= 2; e_m_req <= 1'b1; age <= 0;
          run <= i_req ? ((run < SMAX) ? run + 1 : run) : 0;
          e_m_we <= d_we; e_m_wstrb <= d_we ? d_wstrb : 4'b0000;
          e_m_addr <= d_addr; e_m_wdata <= d_wdata;
        end else begin
          run <= 0;
        end
      end else if (m_ack || age + 1 == TMO) begin
        if (!m_ack) e_bus_err <= 1'b1;
        if (owner == 1) begin
          e_i_ready <= 1'b1; e_i_rdata <= m_ack ? m_rdata : 32'h0;
        end else begin
          e_d_ready <= 1'b1; e_d_rdata <= m_ack ? m_rdata : 32'h0;
        end
        e_m_req <= 1'b0; owner <= 0; resp_due <= 1'b1;
      end else begin
        age <= age + 1;
      end
    end
  end

  bit chk_en = 1'b0;

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_i_ready", 32'(i_ready), 32'(e_i_ready));
      chk("cmp_d_ready", 32'(d_ready), 32'(e_d_ready));
      chk("cmp_i_rdata", i_rdata, e_i_rdata);
      chk("cmp_d_rdata", d_rdata, e_d_rdata);
      chk("cmp_m_req", 32'(m_req), 32'(e_m_req));
      chk("cmp_bus_err", 32'(bus_err), 32'(e_bus_err));
      if (e_m_req || !rst_n) begin
        chk("cmp_m_addr", m_addr, e_m_addr);
        chk("cmp_m_we", 32'(m_we), 32'(e_m_we));
        chk("cmp_m_wstrb", 32'(m_wstrb), 32'(e_m_wstrb));
        if (e_m_we || !rst_n) chk("cmp_m_wdata", m_wdata, e_m_wdata);
      end
    end
  end

  // Memory responder and random requesters, driven 1 time unit after each rising edge
  int          mcnt = 0;
  int          ack_lat = 0;
  bit          rand_lat = 1'b0;
  bit          stray_en = 1'b0;
  bit          rnd_req = 1'b0;
  logic [31:0] next_rdata = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    m_ack = 1'b0;
    if (m_req) begin
      if (mcnt == 0 && rand_lat) begin
        case ($urandom_range(0, 15))
          0:       ack_lat = 0;
          1:       ack_lat = 7;
          default: ack_lat = int'($urandom_range(1, 4));
        endcase
      end
      mcnt++;
      if (ack_lat != 0 && mcnt == ack_lat) begin
        m_ack = 1'b1;
        m_rdata = rand_lat ? $urandom : next_rdata;
      end
    end else begin
      mcnt = 0;
      if (stray_en && $urandom_range(0, 15) == 0) begin
        m_ack = 1'b1;
        m_rdata = $urandom;
      end
    end
    if (rnd_req) begin
      if (i_req && i_ready) i_req = 1'b0;
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_req && d_ready) d_req = 1'b0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
  endtask

  int    n;
  int    g;
  bit    done;
  bit    flag;
  bit    prev;
  string order;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    tick(); tick();
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_readies", 32'({i_ready, d_ready}), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: fetch only, ack two cycles after m_req
    ack_lat = 2; next_rdata = 32'h0000_0013; i_addr = 32'h0000_0010; i_req = 1'b1;
    n = 0; done = 1'b0; flag = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (m_req) begin
        n++;
        chk("t1_m_we", 32'(m_we), 32'h0);
      end
      if (d_ready) flag = 1'b1;
      if (i_ready) begin
        done = 1'b1;
        chk("t1_i_rdata", i_rdata, 32'h0000_0013);
      end
    end
    i_req = 1'b0;
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_m_req_cycles", 32'(n), 32'd2);
    chk("t1_no_d_ready", 32'(flag), 32'h0);
    tick();
    chk("t1_ready_one_cycle", 32'(i_ready), 32'h0);
    tick();

    // 2: simultaneous requests, store wins first
    i_addr = 32'h0000_0020; d_addr = 32'h0000_0100; d_we = 1'b1; d_wstrb = 4'b0011;
    d_wdata = 32'hDEAD_BEEF; ack_lat = 1; next_rdata = 32'h1234_5678;
    i_req = 1'b1; d_req = 1'b1;
    g = 0; flag = 1'b0; done = 1'b0; prev = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (m_req && !prev) begin
        g++;
        if (g == 1) begin
          chk("t2_g1_addr", m_addr, 32'h0000_0100);
          chk("t2_g1_we", 32'(m_we), 32'h1);
          chk("t2_g1_wstrb", 32'(m_wstrb), 32'h3);
          chk("t2_g1_wdata", m_wdata, 32'hDEAD_BEEF);
        end else begin
          chk("t2_g2_addr", m_addr, 32'h0000_0020);
          chk("t2_fetch_after_d_ready", 32'(flag), 32'h1);
        end
      end
      prev = m_req;
      if (d_ready) begin
        flag = 1'b1; d_req = 1'b0; d_we = 1'b0;
        chk("t2_d_rdata", d_rdata, 32'h1234_5678);
      end
      if (i_ready) begin
        done = 1'b1; i_req = 1'b0;
      end
    end
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_grants", 32'(g), 32'd2);
    tick(); tick();

    // 3: starvation relief, both requesters held
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; d_we = 1'b0; ack_lat = 1;
    next_rdata = 32'hA5A5_A5A5; i_req = 1'b1; d_req = 1'b1;
    order = ""; prev = 1'b0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (m_req && !prev) order = {order, (m_addr == 32'h0000_1000) ? "I" : "D"};
      prev = m_req;
      if (order.len() == 10 && (i_ready || d_ready)) done = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (order != "DDDDIDDDDI") begin
      failures++;
      $display("FAIL t3_grant_order actual=%s required=DDDDIDDDDI", order);
    end
    tick(); tick();

    // 4: timeout on a load, bus_err sticks across a later good fetch
    d_addr = 32'h0000_0300; d_we = 1'b0; ack_lat = 0; d_req = 1'b1;
    n = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (m_req) n++;
      if (d_ready) begin
        done = 1'b1; d_req = 1'b0;
        chk("t4_d_rdata_zero", d_rdata, 32'h0);
        chk("t4_bus_err", 32'(bus_err), 32'h1);
        chk("t4_no_i_ready", 32'(i_ready), 32'h0);
      end
    end
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_m_req_cycles", 32'(n), 32'(TMO));
    ack_lat = 3; next_rdata = 32'hCAFE_F00D; i_addr = 32'h0000_0050; i_req = 1'b1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (i_ready) begin
        done = 1'b1; i_req = 1'b0;
        chk("t4_i_rdata", i_rdata, 32'hCAFE_F00D);
        chk("t4_bus_err_sticky", 32'(bus_err), 32'h1);
      end
    end
    chk("t4_fetch_done", 32'(done), 32'h1);
    tick();

    // 5: reset while BUSY
    ack_lat = 0; i_addr = 32'h0000_0040; i_req = 1'b1;
    tick(); tick(); tick();
    chk("t5_busy_m_req", 32'(m_req), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_m_req", 32'(m_req), 32'h0);
    chk("t5_rst_readies", 32'({i_ready, d_ready}), 32'h0);
    chk("t5_rst_bus_err", 32'(bus_err), 32'h0);
    i_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_ack = 1'b1; m_rdata = 32'h0000_0055;
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (i_ready || d_ready) flag = 1'b1;
    end
    chk("t5_late_ack_ignored", 32'(flag), 32'h0);
    chk("t5_i_rdata_cleared", i_rdata, 32'h0);
    ack_lat = 2; next_rdata = 32'h0000_0077; i_req = 1'b1; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (i_ready) begin
        done = 1'b1; i_req = 1'b0;
        chk("t5_fresh_i_rdata", i_rdata, 32'h0000_0077);
      end
    end
    chk("t5_fresh_done", 32'(done), 32'h1);
    tick(); tick();

    // 6: stray ack in IDLE
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (i_ready || d_ready) flag = 1'b1;
    end
    chk("t6_no_ready", 32'(flag), 32'h0);
    chk("t6_i_rdata_kept", i_rdata, 32'h0000_0077);
    chk("t6_d_rdata_kept", d_rdata, 32'h0);

    // Random traffic, checked every cycle by the model comparison
    rand_lat = 1'b1; stray_en = 1'b1; rnd_req = 1'b1;
    repeat (3000) tick();
    rnd_req = 1'b0; stray_en = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
